// File: rtl/cpu_pkg.sv
// Shared CPU-side types: PC command codes and trap causes.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_STEP = 2'd1,
        PC_JUMP = 2'd2
    } pc_ctl_t;

    typedef enum logic [1:0] {
        TRAP_NONE     = 2'd0,
        TRAP_MISALIGN = 2'd1,
        TRAP_TIMEOUT  = 2'd2
    } trap_cause_t;

endpackage

// File: rtl/fetch_sequencer_timer.sv
// Fetch wait counter: clears on demand, counts while enabled, flags TIMEOUT_CYC-1.
module fetch_timer #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_clear,
    output logic o_tc
);

    localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] r_count;

    // Saturates at the terminal count so a stalled enable cannot wrap past it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en && !o_tc) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_tc = (r_count == TC_VAL);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/execute/update sequencer: drives imem requests, hands words to decode,
// commands the PC and traps on misaligned PC or fetch timeout.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             run,
    input  logic             pc_misaligned,
    output logic             imem_req,
    input  logic             imem_ready,
    input  logic [XLEN-1:0]  imem_rdata,
    output logic [XLEN-1:0]  instr,
    output logic             instr_valid,
    input  logic             exec_done,
    input  logic             exec_jump,
    input  logic [XLEN-1:0]  exec_offset,
    output pc_ctl_t          pc_ctl,
    output logic [XLEN-1:0]  pc_addr_in,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_UPDATE = 3'd3;
    localparam logic [2:0] S_TRAP   = 3'd4;

    logic [2:0]       r_state,       w_state_nxt;
    logic [XLEN-1:0]  r_instr,       w_instr_nxt;
    logic             r_instr_valid, w_instr_valid_nxt;
    logic             r_jump,        w_jump_nxt;
    logic [XLEN-1:0]  r_offset,      w_offset_nxt;
    logic             r_trap,        w_trap_nxt;
    trap_cause_t      r_trap_cause,  w_trap_cause_nxt;
    logic [CNT_W-1:0] r_retired,     w_retired_nxt;

    logic w_in_fetch;
    logic w_timer_clr;
    logic w_timeout;

    assign w_in_fetch  = (r_state == S_FETCH);
    assign w_timer_clr = !w_in_fetch || imem_ready;

    fetch_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .i_en    (w_in_fetch),
        .i_clear (w_timer_clr),
        .o_tc    (w_timeout)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state       <= S_IDLE;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_jump        <= 1'b0;
            r_offset      <= '0;
            r_trap        <= 1'b0;
            r_trap_cause  <= TRAP_NONE;
            r_retired     <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_valid <= w_instr_valid_nxt;
            r_jump        <= w_jump_nxt;
            r_offset      <= w_offset_nxt;
            r_trap        <= w_trap_nxt;
            r_trap_cause  <= w_trap_cause_nxt;
            r_retired     <= w_retired_nxt;
        end
    end

    // Ready wins over timeout in the same FETCH cycle
    always_comb begin
        w_state_nxt       = r_state;
        w_instr_nxt       = r_instr;
        w_instr_valid_nxt = r_instr_valid;
        w_jump_nxt        = r_jump;
        w_offset_nxt      = r_offset;
        w_trap_nxt        = r_trap;
        w_trap_cause_nxt  = r_trap_cause;
        w_retired_nxt     = r_retired;
        case (r_state)
            S_IDLE: begin
                if (run && pc_misaligned) begin
                    w_state_nxt      = S_TRAP;
                    w_trap_nxt       = 1'b1;
                    w_trap_cause_nxt = TRAP_MISALIGN;
                end else if (run) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_ready) begin
                    w_instr_nxt       = imem_rdata;
                    w_instr_valid_nxt = 1'b1;
                    w_state_nxt       = S_EXEC;
                end else if (w_timeout) begin
                    w_state_nxt      = S_TRAP;
                    w_trap_nxt       = 1'b1;
                    w_trap_cause_nxt = TRAP_TIMEOUT;
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    w_jump_nxt        = exec_jump;
                    w_offset_nxt      = exec_offset;
                    w_instr_valid_nxt = 1'b0;
                    w_state_nxt       = S_UPDATE;
                end
            end
            S_UPDATE: begin
                w_retired_nxt = r_retired + CNT_W'(1);
                w_state_nxt   = S_IDLE;
            end
            S_TRAP: begin
                w_state_nxt = S_TRAP;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // PC command is a pure decode of the one-cycle UPDATE state
    always_comb begin
        pc_ctl     = PC_HOLD;
        pc_addr_in = '0;
        if (r_state == S_UPDATE) begin
            if (r_jump) begin
                pc_ctl     = PC_JUMP;
                pc_addr_in = r_offset;
            end else begin
                pc_ctl = PC_STEP;
            end
        end
    end

    assign imem_req    = w_in_fetch;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign trap        = r_trap;
    assign trap_cause  = r_trap_cause;
    assign retired     = r_retired;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized self-checking bench for fetch_sequencer with a bench-side PC model.
module tb_fetch_sequencer;
    import cpu_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        run = 1'b0;
    logic        pc_misaligned;
    logic        imem_req;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        exec_done = 1'b0;
    logic        exec_jump = 1'b0;
    logic [31:0] exec_offset = '0;
    pc_ctl_t     pc_ctl;
    logic [31:0] pc_addr_in;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [31:0] retired;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_sequencer #(
        .TIMEOUT_CYC (16),
        .CNT_W       (32)
    ) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .run           (run),
        .pc_misaligned (pc_misaligned),
        .imem_req      (imem_req),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .exec_done     (exec_done),
        .exec_jump     (exec_jump),
        .exec_offset   (exec_offset),
        .pc_ctl        (pc_ctl),
        .pc_addr_in    (pc_addr_in),
        .trap          (trap),
        .trap_cause    (trap_cause),
        .retired       (retired)
    );

    always #5 Clk = ~Clk;

    // Stand-in for the pc block: obeys whatever command the sequencer issues
    logic [31:0] pc_q;
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)                pc_q <= '0;
        else if (pc_ctl == PC_STEP)  pc_q <= pc_q + 32'd4;
        else if (pc_ctl == PC_JUMP)  pc_q <= pc_q + pc_addr_in;
    end
    assign pc_misaligned = (pc_q[1:0] != 2'b00);

    int      n_pulse = 0;
    int      n_double = 0;
    pc_ctl_t prev_ctl = PC_HOLD;
    always @(negedge Clk) begin
        if (pc_ctl != PC_HOLD) begin
            n_pulse <= n_pulse + 1;
            if (prev_ctl != PC_HOLD) n_double <= n_double + 1;
        end
        prev_ctl <= pc_ctl;
    end

    // Observations captured by the instruction driver
    logic        obs_req_ok, obs_hold_ok, obs_valid, obs_req_exec, obs_valid_upd;
    logic [31:0] obs_instr, obs_addr, obs_ret;
    pc_ctl_t     obs_ctl, obs_ctl_next;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic do_reset();
        Reset_n = 1'b0; run = 1'b0; imem_ready = 1'b0; imem_rdata = '0;
        exec_done = 1'b0; exec_jump = 1'b0; exec_offset = '0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
    endtask

    // Runs one instruction from IDLE: ready after flat stall cycles, done after elat
    task automatic drive_instr(input int flat, input int elat, input bit jmp,
                               input logic [31:0] off, input logic [31:0] word,
                               input bit drop_run);
        run = 1'b1; exec_done = 1'b0; imem_ready = 1'b0;
        obs_req_ok = 1'b1; obs_hold_ok = 1'b1;
        @(negedge Clk);
        for (int k = 0; k <= flat; k++) begin
            if (imem_req !== 1'b1 || instr_valid !== 1'b0 || trap !== 1'b0) obs_req_ok = 1'b0;
            imem_ready = (k == flat);
            imem_rdata = (k == flat) ? word : $urandom();
            exec_done  = 1'($urandom_range(0, 1));
            exec_jump  = 1'($urandom_range(0, 1));
            @(negedge Clk);
        end
        imem_ready = 1'b0; imem_rdata = $urandom();
        obs_instr = instr; obs_valid = instr_valid; obs_req_exec = imem_req;
        if (drop_run) run = 1'b0;
        for (int k = 0; k <= elat; k++) begin
            if (instr !== word || instr_valid !== 1'b1 || imem_req !== 1'b0 || pc_ctl !== PC_HOLD)
                obs_hold_ok = 1'b0;
            exec_done   = (k == elat);
            exec_jump   = (k == elat) ? jmp : 1'($urandom_range(0, 1));
            exec_offset = (k == elat) ? off : $urandom();
            imem_ready  = 1'($urandom_range(0, 1));
            @(negedge Clk);
        end
        exec_jump = 1'($urandom_range(0, 1)); exec_offset = $urandom(); imem_ready = 1'b0;
        obs_ctl = pc_ctl; obs_addr = pc_addr_in; obs_valid_upd = instr_valid;
        exec_done = 1'($urandom_range(0, 1));
        @(negedge Clk);
        exec_done = 1'b0;
        obs_ctl_next = pc_ctl; obs_ret = retired;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; run = 1'b1; imem_ready = 1'b1; exec_done = 1'b1;
        repeat (2) @(negedge Clk);
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b exp 0", imem_req); end
        n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h exp 0", instr); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b exp 0", instr_valid); end
        n_checks++; if (pc_ctl !== PC_HOLD) begin n_fail++; $display("FAIL reset_pc_ctl: got %0d exp %0d", pc_ctl, PC_HOLD); end
        n_checks++; if (pc_addr_in !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h exp 0", pc_addr_in); end
        n_checks++; if (trap !== 1'b0 || trap_cause !== 2'd0) begin n_fail++; $display("FAIL reset_trap: got %0b/%0d exp 0/0", trap, trap_cause); end
        n_checks++; if (retired !== 32'h0) begin n_fail++; $display("FAIL reset_retired: got %0d exp 0", retired); end
        run = 1'b0; imem_ready = 1'b0; exec_done = 1'b0;
        Reset_n = 1'b1;
        repeat (3) @(negedge Clk);
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL idle_no_run_req: got %0b exp 0", imem_req); end
    endtask

    task automatic test_step();
        logic [31:0] w;
        logic [31:0] exp_pc;
        do_reset();
        exp_pc = 32'h0;
        for (int i = 0; i < 3; i++) begin
            w = $urandom();
            drive_instr(0, 0, 1'b0, 32'h0, w, 1'b0);
            exp_pc = exp_pc + 32'd4;
            n_checks++; if (obs_instr !== w || obs_valid !== 1'b1) begin n_fail++; $display("FAIL step_instr[%0d]: got %h/%0b exp %h/1", i, obs_instr, obs_valid, w); end
            n_checks++; if (obs_ctl !== PC_STEP || obs_addr !== 32'h0) begin n_fail++; $display("FAIL step_ctl[%0d]: got %0d/%h exp %0d/0", i, obs_ctl, obs_addr, PC_STEP); end
            n_checks++; if (obs_ctl_next !== PC_HOLD) begin n_fail++; $display("FAIL step_pulse_len[%0d]: got %0d exp %0d", i, obs_ctl_next, PC_HOLD); end
            n_checks++; if (obs_ret !== 32'(i + 1)) begin n_fail++; $display("FAIL step_retired[%0d]: got %0d exp %0d", i, obs_ret, i + 1); end
            n_checks++; if (pc_q !== exp_pc) begin n_fail++; $display("FAIL step_pc[%0d]: got %h exp %h", i, pc_q, exp_pc); end
        end
        n_checks++; if (pc_q !== 32'hC || retired !== 32'd3) begin n_fail++; $display("FAIL step_final: got pc %h ret %0d exp pc c ret 3", pc_q, retired); end
    endtask

    task automatic test_jump();
        do_reset();
        drive_instr(0, 0, 1'b0, 32'h0, $urandom(), 1'b0);
        drive_instr(2, 1, 1'b1, 32'h20, $urandom(), 1'b0);
        n_checks++; if (obs_ctl !== PC_JUMP || obs_addr !== 32'h20) begin n_fail++; $display("FAIL jump_ctl: got %0d/%h exp %0d/20", obs_ctl, obs_addr, PC_JUMP); end
        n_checks++; if (pc_q !== 32'h24) begin n_fail++; $display("FAIL jump_pc: got %h exp 24", pc_q); end
        n_checks++; if (obs_hold_ok !== 1'b1 || obs_req_ok !== 1'b1) begin n_fail++; $display("FAIL jump_hold: got %0b/%0b exp 1/1", obs_hold_ok, obs_req_ok); end
    endtask

    task automatic test_misalign();
        int req_cnt;
        do_reset();
        drive_instr(0, 0, 1'b0, 32'h0, $urandom(), 1'b0);
        drive_instr(0, 0, 1'b1, 32'h2, $urandom(), 1'b0);
        n_checks++; if (pc_q !== 32'h6 || trap !== 1'b0) begin n_fail++; $display("FAIL misalign_pre: got pc %h trap %0b exp pc 6 trap 0", pc_q, trap); end
        req_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge Clk);
            if (imem_req === 1'b1) req_cnt++;
            imem_ready = 1'($urandom_range(0, 1));
        end
        imem_ready = 1'b0;
        n_checks++; if (req_cnt != 0) begin n_fail++; $display("FAIL misalign_req: got %0d exp 0", req_cnt); end
        n_checks++; if (trap !== 1'b1 || trap_cause !== 2'd1) begin n_fail++; $display("FAIL misalign_trap: got %0b/%0d exp 1/1", trap, trap_cause); end
    endtask

    task automatic test_timeout();
        int          req_cnt;
        logic        trap16;
        logic [31:0] w;
        do_reset();
        run = 1'b1; imem_ready = 1'b0;
        req_cnt = 0; trap16 = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge Clk);
            if (imem_req === 1'b1) req_cnt++;
            if (k == 16) trap16 = trap;
        end
        @(negedge Clk);
        n_checks++; if (req_cnt != 16) begin n_fail++; $display("FAIL timeout_req_cycles: got %0d exp 16", req_cnt); end
        n_checks++; if (trap16 !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %0b exp 0", trap16); end
        n_checks++; if (trap !== 1'b1 || trap_cause !== 2'd2 || imem_req !== 1'b0) begin n_fail++; $display("FAIL timeout_trap: got %0b/%0d req %0b exp 1/2 req 0", trap, trap_cause, imem_req); end
        imem_ready = 1'b1; exec_done = 1'b1;
        repeat (4) @(negedge Clk);
        imem_ready = 1'b0; exec_done = 1'b0;
        n_checks++; if (trap !== 1'b1 || imem_req !== 1'b0 || pc_q !== 32'h0 || retired !== 32'h0) begin n_fail++; $display("FAIL trap_sticky: got trap %0b req %0b pc %h ret %0d exp 1 0 0 0", trap, imem_req, pc_q, retired); end
        do_reset();
        w = $urandom();
        drive_instr(15, 0, 1'b0, 32'h0, w, 1'b0);
        n_checks++; if (obs_req_ok !== 1'b1 || obs_instr !== w || trap !== 1'b0) begin n_fail++; $display("FAIL ready_at_limit: got req_ok %0b instr %h trap %0b exp 1 %h 0", obs_req_ok, obs_instr, trap, w); end
        n_checks++; if (retired !== 32'd1 || pc_q !== 32'h4) begin n_fail++; $display("FAIL ready_at_limit_pc: got ret %0d pc %h exp 1 4", retired, pc_q); end
    endtask

    task automatic test_run_drop();
        int p0;
        int req_cnt;
        do_reset();
        p0 = n_pulse;
        drive_instr(1, 2, 1'b0, 32'h0, $urandom(), 1'b1);
        n_checks++; if (obs_ctl !== PC_STEP || obs_hold_ok !== 1'b1) begin n_fail++; $display("FAIL run_drop_ctl: got %0d hold %0b exp %0d hold 1", obs_ctl, obs_hold_ok, PC_STEP); end
        req_cnt = 0;
        repeat (8) begin
            @(negedge Clk);
            if (imem_req === 1'b1) req_cnt++;
        end
        n_checks++; if (req_cnt != 0) begin n_fail++; $display("FAIL run_drop_idle: got %0d requests exp 0", req_cnt); end
        n_checks++; if (n_pulse - p0 != 1 || pc_q !== 32'h4 || retired !== 32'd1) begin n_fail++; $display("FAIL run_drop_pc: got pulses %0d pc %h ret %0d exp 1 4 1", n_pulse - p0, pc_q, retired); end
    endtask

    task automatic test_reset_mid();
        int p0;
        do_reset();
        drive_instr(0, 0, 1'b0, 32'h0, $urandom(), 1'b0);
        @(negedge Clk);
        imem_ready = 1'b1; imem_rdata = 32'hDEADBEEF;
        @(negedge Clk);
        imem_ready = 1'b0;
        n_checks++; if (instr_valid !== 1'b1 || instr !== 32'hDEADBEEF) begin n_fail++; $display("FAIL mid_pre: got %0b/%h exp 1/deadbeef", instr_valid, instr); end
        p0 = n_pulse;
        exec_done = 1'b1; exec_jump = 1'b1; exec_offset = 32'h40;
        #2 Reset_n = 1'b0;
        #1;
        n_checks++; if (instr !== 32'h0 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL mid_async_instr: got %h/%0b req %0b exp 0/0 req 0", instr, instr_valid, imem_req); end
        n_checks++; if (pc_ctl !== PC_HOLD || pc_addr_in !== 32'h0 || retired !== 32'h0 || trap !== 1'b0) begin n_fail++; $display("FAIL mid_async_ctl: got ctl %0d addr %h ret %0d trap %0b exp 0 0 0 0", pc_ctl, pc_addr_in, retired, trap); end
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1; run = 1'b0; exec_done = 1'b0; exec_jump = 1'b0;
        repeat (3) @(negedge Clk);
        n_checks++; if (n_pulse != p0 || imem_req !== 1'b0 || pc_q !== 32'h0) begin n_fail++; $display("FAIL mid_no_pulse: got pulses %0d req %0b pc %h exp 0 0 0", n_pulse - p0, imem_req, pc_q); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pc, exp_ret, w, off, exp_addr;
        int          flat, elat;
        bit          jmp, drop;
        pc_ctl_t     exp_ctl;
        do_reset();
        exp_pc = '0; exp_ret = '0;
        for (int i = 0; i < 40; i++) begin
            flat = $urandom_range(0, 15);
            elat = $urandom_range(0, 4);
            jmp  = 1'($urandom_range(0, 1));
            drop = ($urandom_range(0, 7) == 0);
            w    = $urandom();
            if ($urandom_range(0, 1) == 1) off = 32'($urandom_range(0, 255)) << 2;
            else                           off = 32'h0 - (32'($urandom_range(1, 64)) << 2);
            drive_instr(flat, elat, jmp, off, w, drop);
            exp_ctl  = jmp ? PC_JUMP : PC_STEP;
            exp_addr = jmp ? off : 32'h0;
            exp_pc   = exp_pc + (jmp ? off : 32'd4);
            exp_ret  = exp_ret + 32'd1;
            n_checks++; if (obs_req_ok !== 1'b1 || obs_req_exec !== 1'b0) begin n_fail++; $display("FAIL b2b_req[%0d]: got ok %0b exec_req %0b exp 1 0", i, obs_req_ok, obs_req_exec); end
            n_checks++; if (obs_instr !== w || obs_hold_ok !== 1'b1) begin n_fail++; $display("FAIL b2b_instr[%0d]: got %h hold %0b exp %h hold 1", i, obs_instr, obs_hold_ok, w); end
            n_checks++; if (obs_ctl !== exp_ctl || obs_addr !== exp_addr) begin n_fail++; $display("FAIL b2b_ctl[%0d]: got %0d/%h exp %0d/%h", i, obs_ctl, obs_addr, exp_ctl, exp_addr); end
            n_checks++; if (obs_valid_upd !== 1'b0 || obs_ctl_next !== PC_HOLD) begin n_fail++; $display("FAIL b2b_update[%0d]: got valid %0b next %0d exp 0 %0d", i, obs_valid_upd, obs_ctl_next, PC_HOLD); end
            n_checks++; if (obs_ret !== exp_ret) begin n_fail++; $display("FAIL b2b_retired[%0d]: got %0d exp %0d", i, obs_ret, exp_ret); end
            n_checks++; if (pc_q !== exp_pc) begin n_fail++; $display("FAIL b2b_pc[%0d]: got %h exp %h", i, pc_q, exp_pc); end
        end
        n_checks++; if (trap !== 1'b0 || n_double != 0) begin n_fail++; $display("FAIL b2b_final: got trap %0b double_pulses %0d exp 0 0", trap, n_double); end
    endtask

    initial begin
        test_reset();
        test_step();
        test_jump();
        test_misalign();
        test_timeout();
        test_run_drop();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
